reset_sequencer: RTL

Upstream reset-generation stage for the Murax-on-BlackIce top level. It feeds the CPU's asynchronous reset input and the GRESET button-release event.
- Combines a PLL-lock filter, a debounced GRESET push-button and a minimum-width reset hold into one FSM.
- Produces a clean, registered active-high system reset plus a latched reset-cause code for software.

---
 rtl/reset_sequencer_if.sv | 37 +++
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the reset sequencer's asynchronous inputs and its reset/status outputs.
//   pll_locked      : PLL lock indicator (asynchronous to CLK)
//   button_in       : GRESET push-button level, 1 = pressed (asynchronous)
//   sys_reset       : registered active-high reset to CPU/peripherals
//   reset_cause     : latched cause, 01 power-on, 10 button, 11 PLL lock loss
//   button_event    : one-cycle pulse on debounced button release
//   locked_filtered : qualified lock status
// Modports: slave = sequencer side, master = the block driving the inputs.
`timescale 1ns/1ps

interface reset_sequencer_if;
    logic       pll_locked;
    logic       button_in;
    logic       sys_reset;
    logic [1:0] reset_cause;
    logic       button_event;
    logic       locked_filtered;

    modport slave (
        input  pll_locked,
        input  button_in,
        output sys_reset,
        output reset_cause,
        output button_event,
        output locked_filtered
    );

    modport master (
        output pll_locked,
        output button_in,
        input  sys_reset,
        input  reset_cause,
        input  button_event,
        input  locked_filtered
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Upstream reset generator: PLL-lock filter, debounced GRESET button and a
// minimum-width reset hold, combined in one FSM that drives a registered
// active-high system reset and a latched reset-cause code.
// Ports:
//   CLK       : system clock, rising edge
//   reset_in  : asynchronous active-high global reset
//   bus       : reset_sequencer_if.slave (pll_locked, button_in in;
//               sys_reset, reset_cause, button_event, locked_filtered out)
//
// state     | meaning
// WAIT_LOCK | waiting for qualified PLL lock, reset asserted
// HOLD      | lock qualified, counting the minimum reset width
// RUN       | system out of reset
// BUTTON    | debounced button held, reset asserted until release
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 256,
    parameter int LOCK_FILTER     = 16
) (
    input  logic             CLK,
    input  logic             reset_in,
    reset_sequencer_if.slave bus
);

    localparam int LF_W = $clog2(LOCK_FILTER + 1);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [LF_W-1:0] LF_MAX  = LF_W'(LOCK_FILTER);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
    localparam logic [1:0] CAUSE_LOCK = 2'b11;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        BUTTON    = 2'd3
    } state_t;

    logic            lk_m, lk_s;
    logic            bt_m, bt_s;
    logic [LF_W-1:0] lf_cnt;
    logic            locked_filtered;
    logic            db, db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            button_event_q;
    state_t          state;
    logic [HD_W-1:0] hold_cnt;
    logic            sys_reset_q;
    logic [1:0]      reset_cause_q;

    // Two-flop synchronizers for the asynchronous inputs.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
            bt_m <= 1'b0;
            bt_s <= 1'b0;
        end else begin
            lk_m <= bus.pll_locked;
            lk_s <= lk_m;
            bt_m <= bus.button_in;
            bt_s <= bt_m;
        end
    end

    // Lock filter. The counter tracks the level lk_s is loading on this edge,
    // so a lock sample is counted on the same edge it leaves the synchronizer
    // and a single low sample clears the count on that edge.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            lf_cnt <= '0;
        end else if (!lk_m) begin
            lf_cnt <= '0;
        end else if (lf_cnt != LF_MAX) begin
            lf_cnt <= lf_cnt + 1'b1;
        end
    end

    // A full count always coincides with lk_s high; the term only keeps the
    // qualified status tied to the synchronized level.
    assign locked_filtered = lk_s && (lf_cnt == LF_MAX);

    // Debounce: db flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            db             <= 1'b0;
            db_prev        <= 1'b0;
            db_cnt         <= '0;
            button_event_q <= 1'b0;
        end else begin
            db_prev        <= db;
            button_event_q <= db_prev && !db;
            if (bt_s != db) begin
                if (db_cnt == DB_LAST) begin
                    db     <= ~db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Sequencer FSM. sys_reset is only touched on edges entering or leaving
    // RUN; in every other state it is already high. Lock loss is tested first
    // so it always wins over the button.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            state         <= WAIT_LOCK;
            hold_cnt      <= '0;
            sys_reset_q   <= 1'b1;
            reset_cause_q <= CAUSE_POR;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_filtered) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!locked_filtered) begin
                        state         <= WAIT_LOCK;
                        reset_cause_q <= CAUSE_LOCK;
                    end else if (db) begin
                        state         <= BUTTON;
                        reset_cause_q <= CAUSE_BTN;
                    end else if (hold_cnt == HD_LAST) begin
                        state       <= RUN;
                        sys_reset_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_filtered) begin
                        state         <= WAIT_LOCK;
                        sys_reset_q   <= 1'b1;
                        reset_cause_q <= CAUSE_LOCK;
                    end else if (db) begin
                        state         <= BUTTON;
                        sys_reset_q   <= 1'b1;
                        reset_cause_q <= CAUSE_BTN;
                    end
                end
                BUTTON: begin
                    if (!locked_filtered) begin
                        state         <= WAIT_LOCK;
                        reset_cause_q <= CAUSE_LOCK;
                    end else if (!db) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sys_reset       = sys_reset_q;
    assign bus.reset_cause     = reset_cause_q;
    assign bus.button_event    = button_event_q;
    assign bus.locked_filtered = locked_filtered;

endmodule
